// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: start/operand request bundle plus busy/done/Product result bundle.
// Latency: none, wires only. Backpressure: start is honoured only while busy is low.
// Ports: start, A, B (requester to multiplier); busy, done, Product (multiplier to requester).
interface seq_multiplier_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   Product;

  // The requester drives the operands and reads the result.
  modport master (
    output start, A, B,
    input  busy, done, Product
  );

  // The multiplier samples the operands and drives the result.
  modport slave (
    input  start, A, B,
    output busy, done, Product
  );
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned shift-add multiplier that forms one partial product per clock.
// Latency: WIDTH+1 cycles from accepted start to done. With EARLY_TERM_EN defined, latency is (MSB index of B)+2, or 2 when B=0.
// Backpressure: start is ignored while busy; there is no queuing. The next start is accepted in the idle cycle after done.
// Ports: clk and rst_n (async active-low) are plain ports. bus (seq_multiplier_if.slave) carries start/A/B in and busy/done/Product out.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_multiplier_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mplier_next;
  logic                 last_step;

  // Accumulate the shifted multiplicand when the current multiplier LSB is set.
  assign acc_next    = mplier[0] ? (acc + mcand) : acc;
  assign mplier_next = mplier >> 1;

`ifdef EARLY_TERM_EN
  // No set bits remain in the multiplier, so the remaining steps would add nothing.
  assign last_step = (cnt == CW'(1)) || (mplier_next == '0);
`else
  assign last_step = (cnt == CW'(1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // busy is always low in IDLE, so start alone is an accepted request.
          if (bus.start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, bus.A};
            mplier <= bus.B;
            cnt    <= CW'(WIDTH);
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          cnt    <= cnt - 1'b1;
          if (last_step) begin
            // Capture the final sum so Product and done are valid together in DONE.
            product_q <= acc_next;
            done_q    <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.Product = product_q;

endmodule
